// File: rtl/iop408_pkg.sv
// iop408_pkg: shared widths and fetch-queue FSM encoding for the IOP408 front end.
package iop408_pkg;
  localparam int IOP_PC_W     = 11;
  localparam int IOP_INSN_W   = 16;
  localparam int IOP_FQ_ENT_W = IOP_PC_W + IOP_INSN_W;
  typedef enum logic [1:0] {
    FQ_IDLE  = 2'd0,
    FQ_RUN   = 2'd1,
    FQ_REDIR = 2'd2
  } fq_state_e;
endpackage

// File: rtl/iop_fq_ring.sv
// iop_fq_ring: DEPTH-entry {pc, insn} register ring with push, pop, flush and occupancy count.
module iop_fq_ring import iop408_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [IOP_FQ_ENT_W-1:0] wdata_i,
  output logic [IOP_FQ_ENT_W-1:0] rdata_o,
  output logic [AW:0]             count_o
);
  logic [IOP_FQ_ENT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i && count_q != '0;
  assign do_push = push_i && count_q != (AW+1)'(DEPTH);
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= wdata_i;
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/iop_fetch_queue.sv
// iop_fetch_queue: IOP408 I-ROM prefetch queue with redirect handling.
// Defining IOP_FQ_STATS_EN adds the saturating fq_stall_cnt output.
module iop_fetch_queue import iop408_pkg::*; #(
  parameter int                  DEPTH    = 4,
  parameter logic [IOP_PC_W-1:0] RESET_PC = 11'h000
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  fetch_en,
  input  logic                  redir_valid,
  input  logic [IOP_PC_W-1:0]   redir_pc,
  output logic [IOP_PC_W-1:0]   IOPIADDR,
  input  logic [IOP_INSN_W-1:0] IOPIDATA,
  output logic                  fq_valid,
  output logic [IOP_INSN_W-1:0] fq_data,
  output logic [IOP_PC_W-1:0]   fq_pc,
  input  logic                  fq_ready
`ifdef IOP_FQ_STATS_EN
  ,
  output logic [15:0]           fq_stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  fq_state_e state_q, state_d;
  logic [IOP_PC_W-1:0] pc_q, pc_d, infl_pc_q;
  logic infl_q, issue;
  logic [CW-1:0] count;
  logic [IOP_FQ_ENT_W-1:0] head;
  // A same-cycle pop earns no credit, so a returning fetch always finds a free slot.
  assign issue = state_q != FQ_IDLE && fetch_en && !redir_valid &&
                 (int'(count) + int'(infl_q)) < DEPTH;
  always_comb begin
    state_d = redir_valid ? FQ_REDIR : fetch_en ? FQ_RUN : FQ_IDLE;
    pc_d    = redir_valid ? redir_pc : issue ? pc_q + 1'b1 : pc_q;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= FQ_IDLE;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= issue;
      if (issue) infl_pc_q <= pc_q;
    end
  end
  iop_fq_ring #(.DEPTH(DEPTH)) u_ring (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push_i  (infl_q && !redir_valid),
    .pop_i   (fq_ready && !redir_valid),
    .flush_i (redir_valid),
    .wdata_i ({infl_pc_q, IOPIDATA}),
    .rdata_o (head),
    .count_o (count)
  );
  assign IOPIADDR        = pc_q;
  assign fq_valid        = count != '0;
  assign {fq_pc, fq_data} = head;
`ifdef IOP_FQ_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) stall_q <= '0;
    else if (redir_valid) stall_q <= '0;
    else if (fq_ready && !fq_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
  end
  assign fq_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_iop_fetch_queue.sv
// tb_iop_fetch_queue: directed checks of iop_fetch_queue against a synchronous ROM model.
module tb_iop_fetch_queue;
  logic        HCLK = 0, HRESETn = 0, fetch_en = 0, redir_valid = 0, fq_ready = 0;
  logic [10:0] redir_pc = '0, IOPIADDR, fq_pc;
  logic [15:0] IOPIDATA = '0, fq_data;
  logic        fq_valid;
  int          n_vec = 0, n_err = 0;
`ifdef IOP_FQ_STATS_EN
  logic [15:0] fq_stall_cnt;
`endif
  iop_fetch_queue dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .fetch_en    (fetch_en),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .IOPIADDR    (IOPIADDR),
    .IOPIDATA    (IOPIDATA),
    .fq_valid    (fq_valid),
    .fq_data     (fq_data),
    .fq_pc       (fq_pc),
    .fq_ready    (fq_ready)
`ifdef IOP_FQ_STATS_EN
    ,
    .fq_stall_cnt(fq_stall_cnt)
`endif
  );
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) IOPIDATA <= 16'h1000 + {5'b0, IOPIADDR};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge HCLK);
    #1;
  endtask
  task automatic do_reset();
    HRESETn = 0; fetch_en = 0; fq_ready = 0; redir_valid = 0;
    tick(2);
    HRESETn = 1;
  endtask
  initial begin
    tick(2);
    chk("rst_valid", fq_valid, 0);
    chk("rst_addr", IOPIADDR, 11'h000);
    chk("rst_pc", fq_pc, 0);
    chk("rst_data", fq_data, 0);
`ifdef IOP_FQ_STATS_EN
    do_reset();
    fq_ready = 1;
    tick(10);
    chk("stall_cnt10", fq_stall_cnt, 10);
    redir_valid = 1; redir_pc = 11'h010;
    tick;
    redir_valid = 0; fq_ready = 0;
    chk("stall_clr", fq_stall_cnt, 0);
`endif
    do_reset();
    fetch_en = 1; fq_ready = 1;
    tick; chk("s_v_c1", fq_valid, 0);
    tick; chk("s_v_c2", fq_valid, 0);
    tick; chk("s_v_c3", fq_valid, 1);
    chk("s_pc0", fq_pc, 0);
    chk("s_d0", fq_data, 16'h1000);
    for (int i = 1; i <= 5; i++) begin
      tick;
      chk("s_valid", fq_valid, 1);
      chk("s_pc", fq_pc, i);
      chk("s_data", fq_data, 16'h1000 + i);
    end
    do_reset();
    fetch_en = 1; fq_ready = 0;
    tick(10);
    chk("full_addr", IOPIADDR, 11'h004);
    chk("full_pc", fq_pc, 0);
    chk("full_data", fq_data, 16'h1000);
    fq_ready = 1;
    for (int i = 1; i <= 7; i++) begin
      tick;
      chk("drain_valid", fq_valid, 1);
      chk("drain_pc", fq_pc, i);
      chk("drain_data", fq_data, 16'h1000 + i);
    end
    do_reset();
    fetch_en = 1; fq_ready = 0;
    tick(5);
    chk("pre_redir_valid", fq_valid, 1);
    chk("pre_redir_addr", IOPIADDR, 11'h004);
    redir_valid = 1; redir_pc = 11'h123; fq_ready = 1;
    tick;
    redir_valid = 0;
    chk("redir_valid0", fq_valid, 0);
    chk("redir_addr", IOPIADDR, 11'h123);
    tick; chk("redir_valid1", fq_valid, 0);
    tick; chk("redir_valid2", fq_valid, 1);
    chk("redir_pc", fq_pc, 11'h123);
    chk("redir_data", fq_data, 16'h1123);
    tick; chk("redir_pc1", fq_pc, 11'h124);
    tick; chk("redir_pc2", fq_pc, 11'h125);
    redir_valid = 1; redir_pc = 11'h7FE;
    tick;
    redir_valid = 0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_valid", fq_valid, 1);
      chk("wrap_pc", fq_pc, (11'h7FE + i) & 11'h7FF);
      tick;
    end
    do_reset();
    fetch_en = 1; fq_ready = 0;
    tick(5);
    chk("mid_valid", fq_valid, 1);
    #2 HRESETn = 0;
    #1;
    chk("arst_valid", fq_valid, 0);
    chk("arst_addr", IOPIADDR, 11'h000);
    chk("arst_pc", fq_pc, 0);
    chk("arst_data", fq_data, 0);
    fetch_en = 0; fq_ready = 1;
    tick(2);
    HRESETn = 1;
    tick(3);
    chk("post_rst_valid", fq_valid, 0);
    chk("post_rst_addr", IOPIADDR, 11'h000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/iop_fetch_queue.md
IOP_FETCH_QUEUE -- requirements
Module: iop_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 11'h000, meaning first fetch address after reset.
REQ-003 SHALL have port HCLK  input  1  single clock; all flops rising-edge.
REQ-004 SHALL have port HRESETn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fetch_en  input  1  allows new fetch issue when high.
REQ-006 SHALL have port redir_valid  input  1  branch/redirect strobe from IOP408 core.
REQ-007 SHALL have port redir_pc  input  11  redirect target halfword address.
REQ-008 SHALL have port IOPIADDR  output  11  I-ROM read address to MFSPM firmware region.
REQ-009 SHALL have port IOPIDATA  input  16  I-ROM data, valid one cycle after IOPIADDR is presented.
REQ-010 SHALL have port fq_valid  output  1  head entry available to core.
REQ-011 SHALL have port fq_data  output  16  head instruction halfword.
REQ-012 SHALL have port fq_pc  output  11  address of head instruction.
REQ-013 SHALL have port fq_ready  input  1  core pops head when fq_valid and fq_ready are both high.

Function
REQ-014 SHALL keep fetch pointer pc_q; IOPIADDR equals pc_q combinationally.
REQ-015 SHALL issue a fetch in a cycle when state is RUN, fetch_en=1, no redirect, and count + inflight (+0 if popping... no credit for same-cycle pop) < DEPTH; on issue pc_q increments by 1 mod 2048 (11'h7FF wraps to 11'h000).
REQ-016 SHALL register issue as inflight flag with its pc; next cycle write IOPIDATA and that pc into tail entry unless killed.
REQ-017 SHALL support simultaneous push and pop; count unchanged, order preserved.
REQ-018 SHALL drive fq_valid = (count != 0), fq_data/fq_pc from head entry registers (no IOPIDATA bypass).
REQ-019 SHALL implement FSM IDLE, RUN, REDIR: IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0 (inflight still completes); any state->REDIR on redir_valid; REDIR->RUN (or IDLE if fetch_en=0) next cycle.
REQ-020 On redir_valid SHALL clear count/pointers, set pc_q<=redir_pc, kill any inflight return, and ignore same-cycle fq_ready pop; redirect overrides push and pop.
REQ-021 SHALL issue redir_pc in the REDIR-following cycle; first fq_valid for target appears 3 cycles after redir_valid cycle (N redirect, N+1 issue, N+2 data, N+3 valid).
REQ-022 SHALL ignore fq_ready when fq_valid=0 (no underflow); SHALL never push when full (guaranteed by REQ-015 credit rule).
REQ-023 SHALL sustain one instruction per cycle when core pops every cycle and DEPTH>=2.

Reset
REQ-024 On HRESETn low SHALL set state=IDLE, pc_q=RESET_PC, count=0, pointers=0, inflight=0, fq_valid=0, fq_data=0, fq_pc=0; IOPIADDR=RESET_PC.
REQ-025 Reset mid-operation SHALL discard queued and inflight entries; no pop completes after reset deassertion until new data fetched.

Configuration
REQ-026 Macro IOP_FQ_STATS_EN defined: SHALL add output fq_stall_cnt (16 bits) counting cycles with fq_ready=1 and fq_valid=0, saturating at 16'hFFFF, cleared by reset and by redir_valid.
REQ-027 Macro IOP_FQ_STATS_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package iop408_pkg SHALL hold IOP_PC_W=11, IOP_INSN_W=16, and FSM state encoding constants.
REQ-029 Queue storage SHALL be sub-module iop_fq_ring (DEPTH x 27-bit register ring, push/pop/flush, count); FSM, pc and credit logic in top.

Verification
REQ-030 Reset then fetch_en=1, fq_ready=1, ROM[n]=16'h1000+n -> fq_valid first high cycle 3, fq_pc 0,1,2,... one per cycle, data 16'h1000,16'h1001,...
REQ-031 fq_ready=0 with fetch_en=1 -> exactly DEPTH (4) issues, then IOPIADDR holds 11'h004, fq_pc stays 0; release fq_ready -> no gap or duplicate.
REQ-032 redir_valid with redir_pc=11'h123 while queue full and inflight -> next cycle count 0, IOPIADDR=11'h123; fq_valid 3 cycles later with fq_pc=11'h123; no old entries emerge.
REQ-033 redir_pc=11'h7FE, continuous pop -> fq_pc sequence 7FE, 7FF, 000, 001.
REQ-034 HRESETn asserted mid-stream with 3 entries queued -> all outputs reset values immediately; after release, IOPIADDR=RESET_PC, no stale fq_valid.
REQ-035 With IOP_FQ_STATS_EN: hold fetch_en=0, fq_ready=1 for 10 cycles after reset -> fq_stall_cnt=10; redirect -> 0.
